rx_control: RTL and testbench
=============================

RX_CONTROL -- requirements
Module: rx_control

Interface
REQ-001 The block SHALL have the following ports; clock and reset are listed first.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 start_bit_detected  input  1  one-cycle pulse from the start-bit detector.
REQ-005 packet_done  input  1  one-cycle pulse from the bit timer when the last bit of a frame has been shifted.
REQ-006 stop_bit  input  1  stop bit captured by the shift register; valid whenever packet_done is high and thereafter.
REQ-007 sbc_clear  output  1  clear strobe to the stop-bit/frame-check logic.
REQ-008 sbc_enable  output  1  sample strobe for the stop-bit check.
REQ-009 enable_timer  output  1  enable to the bit timer, high for the whole reception window.
REQ-010 load_buffer  output  1  one-cycle strobe to load the received byte into the RX data buffer.
REQ-011 framing_error  output  1  registered error flag for the most recent frame.
REQ-012 error_count  output  8  saturating count of framing errors since reset.

Function
REQ-013 The control logic SHALL be a Moore FSM with exactly six states: IDLE, CLEAR, RECEIVE, CHECK, EVAL, LOAD.
REQ-014 sbc_clear, sbc_enable, enable_timer and load_buffer SHALL be decoded from the current state only, never from inputs.
REQ-015 In IDLE, all four strobes are 0; start_bit_detected=1 moves the FSM to CLEAR on the next edge, otherwise it stays in IDLE.
REQ-016 In CLEAR, sbc_clear=1 for exactly one cycle, then the FSM moves unconditionally to RECEIVE.
REQ-017 In RECEIVE, enable_timer=1.
- packet_done=1 moves the FSM to CHECK.
- Otherwise it stays in RECEIVE.
- start_bit_detected is ignored.
REQ-018 In CHECK, sbc_enable=1 for exactly one cycle, then the FSM moves unconditionally to EVAL.
REQ-019 In EVAL, all strobes are 0; framing_error=1 moves the FSM to IDLE, framing_error=0 moves it to LOAD.
REQ-020 In LOAD, load_buffer=1 for exactly one cycle, then the FSM moves unconditionally to IDLE.
REQ-021 framing_error SHALL clear to 0 on the edge leaving CLEAR.
REQ-022 framing_error SHALL load ~stop_bit on the edge leaving CHECK.
REQ-023 framing_error SHALL hold its value at all other edges, including across IDLE, so software can read the last result.
REQ-024 error_count SHALL increment by 1 on the edge leaving CHECK when stop_bit=0, and saturate at 8'hFF with no wrap to 0.
REQ-025 Latency SHALL be as follows, taking edge k as the edge where start_bit_detected=1 is sampled in IDLE:
- sbc_clear is high in cycle k+1.
- enable_timer rises in cycle k+2.
REQ-026 Latency from packet_done sampled at edge p SHALL be as follows:
- enable_timer falls and sbc_enable is high in cycle p+1.
- load_buffer is high in cycle p+3 for a good frame.
- The FSM is back in IDLE at cycle p+4 for a good frame, and at p+3 for a framing error.
REQ-027 Simultaneous start_bit_detected and packet_done in RECEIVE SHALL be treated as packet_done only; the start pulse is dropped.
REQ-028 start_bit_detected arriving in any state other than IDLE SHALL be ignored and not queued.
REQ-029 packet_done arriving in any state other than RECEIVE SHALL be ignored.
REQ-030 At most one of the four strobes SHALL be high in any cycle.

Reset
REQ-031 Asserting n_rst=0 SHALL, immediately and independent of clk, put the FSM in IDLE, drive all four strobes to 0, and set framing_error=0 and error_count=8'h00.
REQ-032 Reset asserted mid-frame in any state SHALL abort the frame: no load_buffer pulse and no error_count change.
REQ-033 After n_rst is released, the FSM SHALL resume from IDLE at the first rising edge.

Verification
REQ-034 Good frame: start pulse, then packet_done with stop_bit=1 after 90 cycles of enable_timer.
- Required: sbc_clear 1 cycle, enable_timer 90 cycles, sbc_enable 1 cycle, load_buffer 1 cycle at p+3.
- Required: framing_error=0, error_count=0.
REQ-035 Bad frame: same sequence with stop_bit=0.
- Required: no load_buffer, framing_error=1 from p+2.
- Required: error_count=1, FSM in IDLE at p+3.
REQ-036 Back-to-back frames: a bad frame, then a good frame.
- Required: framing_error clears on the edge leaving CLEAR of the second frame.
- Required: the second frame produces one load_buffer pulse; error_count stays 1.
REQ-037 Saturation: 256 consecutive bad frames -> error_count=8'hFF and held after the 257th bad frame.
REQ-038 Reset mid-frame: n_rst=0 for 2 cycles while in RECEIVE.
- Required: all outputs 0 asynchronously and FSM in IDLE.
- Required: a following good frame completes normally with load_buffer=1 once.
REQ-039 Spurious inputs:
- start_bit_detected pulsed during RECEIVE and CHECK -> no state change.
- packet_done pulsed in IDLE -> FSM stays in IDLE with all strobes 0.

Source files
------------

// File: rtl/rx_control_if.sv
// Handshake bundle between the UART receive controller and its datapath.
// The slave side is the controller; the master side drives the detector,
// bit-timer and shift-register status into it.
interface rx_control_if;
  logic       start_bit_detected;
  logic       packet_done;
  logic       stop_bit;
  logic       sbc_clear;
  logic       sbc_enable;
  logic       enable_timer;
  logic       load_buffer;
  logic       framing_error;
  logic [7:0] error_count;

  modport master (
    output start_bit_detected, packet_done, stop_bit,
    input  sbc_clear, sbc_enable, enable_timer, load_buffer,
           framing_error, error_count
  );

  modport slave (
    input  start_bit_detected, packet_done, stop_bit,
    output sbc_clear, sbc_enable, enable_timer, load_buffer,
           framing_error, error_count
  );
endinterface

// File: rtl/rx_control.sv
// UART receive controller: Moore FSM sequencing clear, reception window,
// stop-bit check, evaluation and buffer load for one frame at a time.
// The strobes are registered alongside the state so each one is a clean
// flop output that reflects the current state only.
module rx_control (
  input  logic        clk,
  input  logic        n_rst,
  rx_control_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RECEIVE = 3'd2,
    CHECK   = 3'd3,
    EVAL    = 3'd4,
    LOAD    = 3'd5
  } state_t;

  state_t     state;
  logic       sbc_clear_reg;
  logic       sbc_enable_reg;
  logic       enable_timer_reg;
  logic       load_buffer_reg;
  logic       framing_error_reg;
  logic [7:0] error_count_reg;

  // State transitions, strobes for the state being entered, and error tracking.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= IDLE;
      sbc_clear_reg     <= 1'b0;
      sbc_enable_reg    <= 1'b0;
      enable_timer_reg  <= 1'b0;
      load_buffer_reg   <= 1'b0;
      framing_error_reg <= 1'b0;
      error_count_reg   <= 8'h00;
    end else begin
      // Every strobe drops unless the destination state asserts it.
      sbc_clear_reg    <= 1'b0;
      sbc_enable_reg   <= 1'b0;
      enable_timer_reg <= 1'b0;
      load_buffer_reg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_bit_detected) begin
            state         <= CLEAR;
            sbc_clear_reg <= 1'b1;
          end
        end
        CLEAR: begin
          state             <= RECEIVE;
          enable_timer_reg  <= 1'b1;
          framing_error_reg <= 1'b0;
        end
        RECEIVE: begin
          // A start pulse coinciding with packet_done is simply dropped.
          if (bus.packet_done) begin
            state          <= CHECK;
            sbc_enable_reg <= 1'b1;
          end else begin
            enable_timer_reg <= 1'b1;
          end
        end
        CHECK: begin
          state             <= EVAL;
          framing_error_reg <= ~bus.stop_bit;
          if (!bus.stop_bit && (error_count_reg != 8'hFF)) begin
            error_count_reg <= error_count_reg + 8'd1;
          end
        end
        EVAL: begin
          // Decide on the flag registered when leaving CHECK.
          if (framing_error_reg) begin
            state <= IDLE;
          end else begin
            state           <= LOAD;
            load_buffer_reg <= 1'b1;
          end
        end
        LOAD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sbc_clear     = sbc_clear_reg;
  assign bus.sbc_enable    = sbc_enable_reg;
  assign bus.enable_timer  = enable_timer_reg;
  assign bus.load_buffer   = load_buffer_reg;
  assign bus.framing_error = framing_error_reg;
  assign bus.error_count   = error_count_reg;

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control: frame sequencing, latency, error flag,
// saturating counter, asynchronous reset and spurious-input handling.
module tb_rx_control;
  logic clk = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  rx_control_if bus ();

  rx_control dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int fails = 0;

  // Strobe vector: {sbc_clear, sbc_enable, enable_timer, load_buffer}
  logic [3:0] strb;
  assign strb = {bus.sbc_clear, bus.sbc_enable, bus.enable_timer, bus.load_buffer};

  int cnt_clear = 0;
  int cnt_enable = 0;
  int cnt_sbc = 0;
  int cnt_load = 0;
  int multi_hot = 0;

  // Per-cycle strobe tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (n_rst) begin
      cnt_clear  += int'(bus.sbc_clear);
      cnt_sbc    += int'(bus.sbc_enable);
      cnt_enable += int'(bus.enable_timer);
      cnt_load   += int'(bus.load_buffer);
      if ((int'(bus.sbc_clear) + int'(bus.sbc_enable) +
           int'(bus.enable_timer) + int'(bus.load_buffer)) > 1)
        multi_hot++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Frame driven from the CLEAR cycle to cycle p+4.
  task automatic finish_frame(input logic sb, input int len);
    cycle();
    repeat (len - 1) cycle();
    bus.packet_done = 1'b1;
    bus.stop_bit    = sb;
    cycle();
    bus.packet_done = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic frame(input logic sb, input int len);
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    finish_frame(sb, len);
  endtask

  task automatic test_reset();
    bus.start_bit_detected = 1'b0;
    bus.packet_done = 1'b0;
    bus.stop_bit = 1'b1;
    #2;
    checks++;
    if ({strb, bus.framing_error, bus.error_count} !== 13'h0) begin
      fails++;
      $display("FAIL reset_state: strb=%b fe=%b ec=%h, want 0000/0/00", strb, bus.framing_error, bus.error_count);
    end
    @(negedge clk);
    n_rst = 1'b1;
    cycle();
    checks++;
    if (strb !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release_idle: strb=%b want 0000", strb);
    end
    $display("reset: strb=%b fe=%b ec=%h", strb, bus.framing_error, bus.error_count);
  endtask

  task automatic test_good_frame();
    int b_clear, b_enable, b_sbc, b_load;
    b_clear = cnt_clear; b_enable = cnt_enable; b_sbc = cnt_sbc; b_load = cnt_load;
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    checks++;
    if (strb !== 4'b1000) begin fails++; $display("FAIL good_clear_k1: strb=%b want 1000", strb); end
    cycle();
    checks++;
    if (strb !== 4'b0010) begin fails++; $display("FAIL good_timer_k2: strb=%b want 0010", strb); end
    repeat (89) cycle();
    bus.packet_done = 1'b1;
    bus.stop_bit = 1'b1;
    cycle();
    bus.packet_done = 1'b0;
    checks++;
    if (strb !== 4'b0100) begin fails++; $display("FAIL good_check_p1: strb=%b want 0100", strb); end
    cycle();
    checks++;
    if ({strb, bus.framing_error} !== 5'b00000) begin
      fails++; $display("FAIL good_eval_p2: strb=%b fe=%b want 0000/0", strb, bus.framing_error);
    end
    cycle();
    checks++;
    if (strb !== 4'b0001) begin fails++; $display("FAIL good_load_p3: strb=%b want 0001", strb); end
    cycle();
    checks++;
    if (strb !== 4'b0000) begin fails++; $display("FAIL good_idle_p4: strb=%b want 0000", strb); end
    checks++;
    if ((cnt_clear - b_clear) != 1 || (cnt_enable - b_enable) != 90 ||
        (cnt_sbc - b_sbc) != 1 || (cnt_load - b_load) != 1) begin
      fails++;
      $display("FAIL good_widths: clear=%0d timer=%0d sbc=%0d load=%0d want 1/90/1/1",
               cnt_clear - b_clear, cnt_enable - b_enable, cnt_sbc - b_sbc, cnt_load - b_load);
    end
    checks++;
    if (bus.framing_error !== 1'b0 || bus.error_count !== 8'h00) begin
      fails++; $display("FAIL good_flags: fe=%b ec=%h want 0/00", bus.framing_error, bus.error_count);
    end
    $display("good frame: timer cycles=%0d fe=%b ec=%h", cnt_enable - b_enable, bus.framing_error, bus.error_count);
  endtask

  // Bad frame; ends in the CLEAR cycle of the next frame started at p+3.
  task automatic test_bad_frame();
    int b_load;
    b_load = cnt_load;
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    cycle();
    repeat (89) cycle();
    bus.packet_done = 1'b1;
    bus.stop_bit = 1'b0;
    cycle();
    bus.packet_done = 1'b0;
    checks++;
    if (strb !== 4'b0100) begin fails++; $display("FAIL bad_check_p1: strb=%b want 0100", strb); end
    cycle();
    checks++;
    if (bus.framing_error !== 1'b1) begin fails++; $display("FAIL bad_fe_p2: fe=%b want 1", bus.framing_error); end
    cycle();
    checks++;
    if (strb !== 4'b0000 || bus.error_count !== 8'h01) begin
      fails++; $display("FAIL bad_p3: strb=%b ec=%h want 0000/01", strb, bus.error_count);
    end
    checks++;
    if ((cnt_load - b_load) != 0) begin fails++; $display("FAIL bad_no_load: loads=%0d want 0", cnt_load - b_load); end
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    checks++;
    if (strb !== 4'b1000) begin fails++; $display("FAIL bad_idle_p3: strb=%b want 1000", strb); end
    $display("bad frame: fe=%b ec=%h", bus.framing_error, bus.error_count);
  endtask

  // Continues from the CLEAR cycle left by test_bad_frame with a good frame.
  task automatic test_back_to_back();
    int b_load;
    b_load = cnt_load;
    checks++;
    if (bus.framing_error !== 1'b1) begin fails++; $display("FAIL b2b_fe_held_clear: fe=%b want 1", bus.framing_error); end
    cycle();
    checks++;
    if (bus.framing_error !== 1'b0 || strb !== 4'b0010) begin
      fails++; $display("FAIL b2b_fe_cleared: fe=%b strb=%b want 0/0010", bus.framing_error, strb);
    end
    repeat (19) cycle();
    bus.packet_done = 1'b1;
    bus.stop_bit = 1'b1;
    cycle();
    bus.packet_done = 1'b0;
    repeat (3) cycle();
    checks++;
    if ((cnt_load - b_load) != 1 || bus.error_count !== 8'h01 || bus.framing_error !== 1'b0) begin
      fails++;
      $display("FAIL b2b_result: loads=%0d ec=%h fe=%b want 1/01/0", cnt_load - b_load, bus.error_count, bus.framing_error);
    end
    $display("back-to-back: loads=%0d ec=%h", cnt_load - b_load, bus.error_count);
  endtask

  task automatic test_spurious();
    bus.packet_done = 1'b1;
    cycle();
    bus.packet_done = 1'b0;
    checks++;
    if (strb !== 4'b0000) begin fails++; $display("FAIL spur_pd_idle: strb=%b want 0000", strb); end
    cycle();
    checks++;
    if (strb !== 4'b0000) begin fails++; $display("FAIL spur_pd_idle2: strb=%b want 0000", strb); end
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    bus.packet_done = 1'b1;
    cycle();
    bus.packet_done = 1'b0;
    checks++;
    if (strb !== 4'b0010) begin fails++; $display("FAIL spur_pd_clear: strb=%b want 0010", strb); end
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    checks++;
    if (strb !== 4'b0010) begin fails++; $display("FAIL spur_start_receive: strb=%b want 0010", strb); end
    bus.start_bit_detected = 1'b1;
    bus.packet_done = 1'b1;
    bus.stop_bit = 1'b1;
    cycle();
    bus.packet_done = 1'b0;
    checks++;
    if (strb !== 4'b0100) begin fails++; $display("FAIL spur_simultaneous: strb=%b want 0100", strb); end
    cycle();
    bus.start_bit_detected = 1'b0;
    checks++;
    if (strb !== 4'b0000) begin fails++; $display("FAIL spur_start_check: strb=%b want 0000", strb); end
    cycle();
    checks++;
    if (strb !== 4'b0001) begin fails++; $display("FAIL spur_load: strb=%b want 0001", strb); end
    cycle();
    cycle();
    checks++;
    if (strb !== 4'b0000) begin fails++; $display("FAIL spur_not_queued: strb=%b want 0000", strb); end
    $display("spurious: strb=%b ec=%h", strb, bus.error_count);
  endtask

  task automatic test_reset_mid_frame();
    int b_load, b_enable;
    bus.start_bit_detected = 1'b1;
    cycle();
    bus.start_bit_detected = 1'b0;
    repeat (6) cycle();
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({strb, bus.framing_error, bus.error_count} !== 13'h0) begin
      fails++;
      $display("FAIL midrst_async: strb=%b fe=%b ec=%h want 0000/0/00", strb, bus.framing_error, bus.error_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    cycle();
    checks++;
    if ({strb, bus.error_count} !== 12'h0) begin
      fails++; $display("FAIL midrst_idle: strb=%b ec=%h want 0000/00", strb, bus.error_count);
    end
    b_load = cnt_load; b_enable = cnt_enable;
    frame(1'b1, 30);
    checks++;
    if ((cnt_load - b_load) != 1 || (cnt_enable - b_enable) != 30 || bus.error_count !== 8'h00) begin
      fails++;
      $display("FAIL midrst_next_frame: loads=%0d timer=%0d ec=%h want 1/30/00",
               cnt_load - b_load, cnt_enable - b_enable, bus.error_count);
    end
    $display("reset mid-frame: loads=%0d ec=%h", cnt_load - b_load, bus.error_count);
  endtask

  task automatic test_saturation();
    int b_load;
    b_load = cnt_load;
    repeat (254) frame(1'b0, 3);
    checks++;
    if (bus.error_count !== 8'hFE) begin fails++; $display("FAIL sat_254: ec=%h want fe", bus.error_count); end
    frame(1'b0, 3);
    checks++;
    if (bus.error_count !== 8'hFF) begin fails++; $display("FAIL sat_255: ec=%h want ff", bus.error_count); end
    frame(1'b0, 3);
    checks++;
    if (bus.error_count !== 8'hFF) begin fails++; $display("FAIL sat_256: ec=%h want ff", bus.error_count); end
    frame(1'b0, 3);
    checks++;
    if (bus.error_count !== 8'hFF || bus.framing_error !== 1'b1) begin
      fails++; $display("FAIL sat_257: ec=%h fe=%b want ff/1", bus.error_count, bus.framing_error);
    end
    checks++;
    if ((cnt_load - b_load) != 0) begin fails++; $display("FAIL sat_no_load: loads=%0d want 0", cnt_load - b_load); end
    $display("saturation: ec=%h", bus.error_count);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_back_to_back();
    test_spurious();
    test_reset_mid_frame();
    test_saturation();
    checks++;
    if (multi_hot != 0) begin fails++; $display("FAIL one_hot_strobes: cycles=%0d want 0", multi_hot); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
